// File: rtl/arbitro_ram.sv
// arbitro_ram: two-requester round-robin arbiter in front of a single-port
// RAM with a combinational read port and a level-sensitive write strobe.
// One transaction at a time: IDLE -> ACCESS -> DONE -> IDLE (3 cycles min).
// Every output toward the RAM and toward the requesters comes from a flop,
// so there is no combinational path from requester inputs to the RAM.

module arbitro_ram #(
    parameter int m = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    // requester A (CPU)
    input  logic         req_a,
    input  logic         we_a,
    input  logic [m-1:0] addr_a,
    input  logic [m-1:0] wdata_a,
    output logic [m-1:0] rdata_a,
    output logic         ack_a,
    // requester B (loader / DMA)
    input  logic         req_b,
    input  logic         we_b,
    input  logic [m-1:0] addr_b,
    input  logic [m-1:0] wdata_b,
    output logic [m-1:0] rdata_b,
    output logic         ack_b,
    // RAM side
    output logic         ram_le,
    output logic [m-1:0] ram_addr,
    output logic [m-1:0] ram_wdata,
    input  logic [m-1:0] ram_rdata,
    // status
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;

    // arbitration result for the current IDLE cycle
    logic           any_req_s;
    logic           win_b_s;
    logic           win_we_s;
    logic [m-1:0]   win_addr_s;
    logic [m-1:0]   win_wdata_s;

    // latched transaction
    logic           grant_b_r;    // 1: transaction in flight belongs to B
    logic           last_b_r;     // 1: B was granted most recently
    logic           we_lat_r;
    logic [m-1:0]   addr_lat_r;
    logic [m-1:0]   wdata_lat_r;

    // registered outputs
    logic           ram_le_r;
    logic           ack_a_r;
    logic           ack_b_r;
    logic           busy_r;
    logic [m-1:0]   rdata_a_r;
    logic [m-1:0]   rdata_b_r;

    // Round-robin pick: a lone request wins; on a tie the requester that was
    // not granted last time wins. The winner's command is muxed out here.
    always_comb begin
        any_req_s   = req_a | req_b;
        win_b_s     = 1'b0;
        win_we_s    = we_a;
        win_addr_s  = addr_a;
        win_wdata_s = wdata_a;
        if (req_a && req_b) begin
            win_b_s = ~last_b_r;
        end else if (req_b) begin
            win_b_s = 1'b1;
        end else begin
            win_b_s = 1'b0;
        end
        if (win_b_s) begin
            win_we_s    = we_b;
            win_addr_s  = addr_b;
            win_wdata_s = wdata_b;
        end else begin
            win_we_s    = we_a;
            win_addr_s  = addr_a;
            win_wdata_s = wdata_a;
        end
    end

    // Next-state logic: ACCESS and DONE each last exactly one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_next_s = ST_DONE;
            ST_DONE:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture the winning command when a transaction starts; afterwards the
    // requester inputs are ignored until the next IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_b_r   <= 1'b0;
            last_b_r    <= 1'b1;   // A wins the first tie after reset
            we_lat_r    <= 1'b0;
            addr_lat_r  <= {m{1'b0}};
            wdata_lat_r <= {m{1'b0}};
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            grant_b_r   <= win_b_s;
            last_b_r    <= win_b_s;
            we_lat_r    <= win_we_s;
            addr_lat_r  <= win_addr_s;
            wdata_lat_r <= win_wdata_s;
        end
    end

    // Write strobe, acks and busy are computed one cycle ahead so that they
    // line up with ACCESS / DONE while still coming straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_le_r <= 1'b0;
            ack_a_r  <= 1'b0;
            ack_b_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            ram_le_r <= (state_r == ST_IDLE) && any_req_s && win_we_s;
            ack_a_r  <= (state_r == ST_ACCESS) && !grant_b_r;
            ack_b_r  <= (state_r == ST_ACCESS) && grant_b_r;
            busy_r   <= (state_next_s != ST_IDLE);
        end
    end

    // Read data: sampled from the RAM at the end of ACCESS for the granted
    // requester only; writes leave both read registers untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_r <= {m{1'b0}};
            rdata_b_r <= {m{1'b0}};
        end else if ((state_r == ST_ACCESS) && !we_lat_r) begin
            if (grant_b_r) begin
                rdata_b_r <= ram_rdata;
            end else begin
                rdata_a_r <= ram_rdata;
            end
        end
    end

    assign ram_le    = ram_le_r;
    assign ram_addr  = addr_lat_r;
    assign ram_wdata = wdata_lat_r;
    assign ack_a     = ack_a_r;
    assign ack_b     = ack_b_r;
    assign busy      = busy_r;
    assign rdata_a   = rdata_a_r;
    assign rdata_b   = rdata_b_r;

    arbitro_ram_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .ack_a  (ack_a_r),
        .ack_b  (ack_b_r),
        .ram_le (ram_le_r),
        .busy   (busy_r)
    );

endmodule

// Protocol checker for arbitro_ram: observation only, drives nothing.
module arbitro_ram_chk (
    input logic clk,
    input logic rst_n,
    input logic ack_a,
    input logic ack_b,
    input logic ram_le,
    input logic busy
);

    a_ack_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(ack_a && ack_b));

    a_le_only_when_busy: assert property (@(posedge clk) disable iff (!rst_n)
        ram_le |-> busy);

    a_ack_only_when_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (ack_a || ack_b) |-> busy);

    a_le_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        ram_le |=> !ram_le);

endmodule

// File: tb/tb_arbitro_ram.sv
// Self-checking bench for arbitro_ram: a behavioural RAM hangs off the RAM
// port, and a transaction-level model (reference memory, round-robin rule,
// expected read registers) predicts every observable output.

module tb_arbitro_ram;

    localparam int M = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_a, we_a, req_b, we_b;
    logic [M-1:0] addr_a, wdata_a, addr_b, wdata_b;
    logic [M-1:0] rdata_a, rdata_b;
    logic         ack_a, ack_b;
    logic         ram_le;
    logic [M-1:0] ram_addr, ram_wdata, ram_rdata;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    // physical RAM attached to the DUT
    logic [M-1:0] mem [256] = '{default: 8'h00};
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_le) mem[ram_addr] <= ram_wdata;

    always #5 clk = ~clk;

    arbitro_ram #(.m(M)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rdata_a), .ack_a(ack_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b), .ack_b(ack_b),
        .ram_le(ram_le), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    // ---------------- reference model ----------------
    logic [M-1:0] ref_mem [256] = '{default: 8'h00};
    bit           last_b;               // 1: B granted most recently
    logic [M-1:0] exp_rd_a, exp_rd_b;
    bit           pend_a, pend_b;
    bit           t_we_a, t_we_b;
    logic [M-1:0] t_addr_a, t_wd_a, t_addr_b, t_wd_b;
    bit           grants[$];            // observed grant order, 1 = B

    task automatic model_reset();
        last_b   = 1'b1;
        exp_rd_a = 8'h00;
        exp_rd_b = 8'h00;
        pend_a   = 1'b0;
        pend_b   = 1'b0;
    endtask

    task automatic set_a(input bit we, input logic [M-1:0] ad, input logic [M-1:0] wd);
        pend_a = 1'b1; t_we_a = we; t_addr_a = ad; t_wd_a = wd;
    endtask

    task automatic set_b(input bit we, input logic [M-1:0] ad, input logic [M-1:0] wd);
        pend_b = 1'b1; t_we_b = we; t_addr_b = ad; t_wd_b = wd;
    endtask

    // One arbitration round, entered and left on a negedge while IDLE.
    task automatic run_round(input bit disturb);
        bit           wb;
        bit           w_we;
        logic [M-1:0] w_addr, w_wd;
        req_a = pend_a; we_a = t_we_a; addr_a = t_addr_a; wdata_a = t_wd_a;
        req_b = pend_b; we_b = t_we_b; addr_b = t_addr_b; wdata_b = t_wd_b;
        if (!pend_a && !pend_b) begin
            @(negedge clk);
            checks++;
            if ({busy, ram_le, ack_a, ack_b} !== 4'b0000) begin
                failures++;
                $display("FAIL idle_quiet busy/le/ack_a/ack_b=%b expected 0000", {busy, ram_le, ack_a, ack_b});
            end
            return;
        end
        wb     = pend_b && (!pend_a || !last_b);
        w_we   = wb ? t_we_b   : t_we_a;
        w_addr = wb ? t_addr_b : t_addr_a;
        w_wd   = wb ? t_wd_b   : t_wd_a;

        @(negedge clk);   // ACCESS
        checks++;
        if (busy !== 1'b1 || ram_le !== w_we || ram_addr !== w_addr || ram_wdata !== w_wd) begin
            failures++;
            $display("FAIL access busy=%b le=%b addr=%h wdata=%h expected 1 %b %h %h",
                     busy, ram_le, ram_addr, ram_wdata, w_we, w_addr, w_wd);
        end
        checks++;
        if (ack_a !== 1'b0 || ack_b !== 1'b0) begin
            failures++;
            $display("FAIL access_ack ack_a=%b ack_b=%b expected 0 0", ack_a, ack_b);
        end
        if (disturb) begin
            if (wb) addr_b = w_addr ^ 8'h50; else addr_a = w_addr ^ 8'h50;
            #1;
            checks++;
            if (ram_addr !== w_addr) begin
                failures++;
                $display("FAIL addr_stable ram_addr=%h expected %h", ram_addr, w_addr);
            end
        end
        if (w_we) ref_mem[w_addr] = w_wd;
        else if (wb) exp_rd_b = ref_mem[w_addr];
        else exp_rd_a = ref_mem[w_addr];
        last_b = wb;

        @(negedge clk);   // DONE
        checks++;
        if (ack_a !== !wb || ack_b !== wb) begin
            failures++;
            $display("FAIL done_ack ack_a=%b ack_b=%b expected %b %b", ack_a, ack_b, !wb, wb);
        end
        grants.push_back(ack_b);
        checks++;
        if (ram_le !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL done_state le=%b busy=%b expected 0 1", ram_le, busy);
        end
        checks++;
        if (rdata_a !== exp_rd_a || rdata_b !== exp_rd_b) begin
            failures++;
            $display("FAIL rdata rdata_a=%h rdata_b=%h expected %h %h", rdata_a, rdata_b, exp_rd_a, exp_rd_b);
        end
        if (wb) begin req_b = 1'b0; pend_b = 1'b0; end
        else    begin req_a = 1'b0; pend_a = 1'b0; end

        @(negedge clk);   // back in IDLE
        checks++;
        if (busy !== 1'b0 || ack_a !== 1'b0 || ack_b !== 1'b0) begin
            failures++;
            $display("FAIL idle_gap busy=%b ack_a=%b ack_b=%b expected 0 0 0", busy, ack_a, ack_b);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({busy, ram_le, ack_a, ack_b} !== 4'b0000) begin
            failures++;
            $display("FAIL %s_ctl busy/le/ack_a/ack_b=%b expected 0000", tag, {busy, ram_le, ack_a, ack_b});
        end
        checks++;
        if (ram_addr !== 8'h00 || ram_wdata !== 8'h00 || rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
            failures++;
            $display("FAIL %s_data ram_addr=%h ram_wdata=%h rdata_a=%h rdata_b=%h expected all 00",
                     tag, ram_addr, ram_wdata, rdata_a, rdata_b);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
        #1;
        check_reset_values("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 1'b0; we_a = 1'b0; addr_a = 8'h00; wdata_a = 8'h00;
        req_b = 1'b0; we_b = 1'b0; addr_b = 8'h00; wdata_b = 8'h00;
        t_we_a = 1'b0; t_addr_a = 8'h00; t_wd_a = 8'h00;
        t_we_b = 1'b0; t_addr_b = 8'h00; t_wd_b = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        set_a(1'b1, 8'h10, 8'hA5);
        run_round(1'b0);
        set_a(1'b0, 8'h10, 8'h00);
        run_round(1'b0);
        checks++;
        if (rdata_a !== 8'hA5) begin
            failures++;
            $display("FAIL write_read rdata_a=%h expected a5", rdata_a);
        end
    endtask

    task automatic test_tie_after_reset();
        apply_reset();
        grants.delete();
        set_a(1'b0, 8'h10, 8'h00);
        set_b(1'b1, 8'h20, 8'h3C);
        run_round(1'b0);
        run_round(1'b0);
        checks++;
        if (grants.size() != 2 || grants[0] != 1'b0 || grants[1] != 1'b1) begin
            failures++;
            $display("FAIL tie_order grants=%p expected A then B", grants);
        end
        checks++;
        if (mem[8'h20] !== 8'h3C) begin
            failures++;
            $display("FAIL tie_write mem[20]=%h expected 3c", mem[8'h20]);
        end
    endtask

    task automatic test_alternate();
        grants.delete();
        for (int i = 0; i < 6; i++) begin
            if (!pend_a) set_a(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            if (!pend_b) set_b(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            run_round(1'b0);
        end
        pend_a = 1'b0; pend_b = 1'b0;
        checks++;
        if (grants.size() != 6 || grants[0] != 1'b0 || grants[1] != 1'b1 || grants[2] != 1'b0 ||
            grants[3] != 1'b1 || grants[4] != 1'b0 || grants[5] != 1'b1) begin
            failures++;
            $display("FAIL alternate grants=%p expected A B A B A B", grants);
        end
    endtask

    task automatic test_no_clobber();
        apply_reset();
        set_a(1'b0, 8'h10, 8'h00);
        run_round(1'b0);
        set_b(1'b1, 8'h11, 8'h77);
        run_round(1'b0);
        checks++;
        if (rdata_a !== 8'hA5 || rdata_b !== 8'h00) begin
            failures++;
            $display("FAIL no_clobber rdata_a=%h rdata_b=%h expected a5 00", rdata_a, rdata_b);
        end
    endtask

    task automatic test_addr_stable();
        set_a(1'b0, 8'h10, 8'h00);
        run_round(1'b1);   // addr_a moves 0x10 -> 0x40 mid-ACCESS
    endtask

    task automatic test_reset_in_access();
        logic [M-1:0] old;
        old = mem[8'h30];
        req_a = 1'b0;
        req_b = 1'b1; we_b = 1'b1; addr_b = 8'h30; wdata_b = 8'h55;
        @(negedge clk);
        checks++;
        if (ram_le !== 1'b1 || ram_addr !== 8'h30) begin
            failures++;
            $display("FAIL rst_access_pre le=%b addr=%h expected 1 30", ram_le, ram_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("rst_access");
        req_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ack_a !== 1'b0 || ack_b !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rst_no_ack ack_a=%b ack_b=%b busy=%b expected 0 0 0", ack_a, ack_b, busy);
            end
        end
        checks++;
        if (mem[8'h30] !== old) begin
            failures++;
            $display("FAIL rst_abort mem[30]=%h expected %h", mem[8'h30], old);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            if (!pend_a && ($urandom_range(0, 3) != 0))
                set_a(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            if (!pend_b && ($urandom_range(0, 3) != 0))
                set_b(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            run_round(1'($urandom_range(0, 3) == 0));
        end
        // drain anything still pending
        for (int i = 0; i < 2; i++) run_round(1'b0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie_after_reset();
        test_alternate();
        test_no_clobber();
        test_addr_stable();
        test_reset_in_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
